fir_sample_source: RTL and testbench
====================================

Name: fir_sample_source

Overview:
- Sample transmitter that feeds the `x` input of `fir_filter`.
- A host loads a small sample buffer through a write port, then issues `start`.
- The block plays the stored samples out on `x`, one per sample period, with a one-cycle `x_valid` strobe per sample.
- Supports single-shot and continuous loop playback, abort, and a programmable rate divider, so the filter can be driven at full or reduced sample rate.

Parameters:
- DATA_W, 16, sample width; matches `fir_filter` `x`.
- DEPTH, 16, number of sample buffer entries.
- ADDR_W, 4, buffer address width; log2(DEPTH).
- DIV_W, 8, rate divider width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  ADDR_W  buffer write address.
- wr_data  input  DATA_W  buffer write data.
- start  input  1  begin playback (single-cycle pulse).
- stop  input  1  abort playback (single-cycle pulse).
- loop  input  1  continuous playback select; sampled at start.
- len  input  ADDR_W+1  number of samples to play; sampled at start.
- rate_div  input  DIV_W  extra cycles per sample; period is rate_div+1; sampled at start.
- x  output  DATA_W  sample to filter (registered).
- x_valid  output  1  high for one cycle when a new sample appears on `x`.
- busy  output  1  high in PLAY.
- done  output  1  high in DONE; held until the next accepted start or reset.

Behaviour:
- Reset values:
  - state IDLE; x=0, x_valid=0, busy=0, done=0.
  - Index and divider counters cleared.
  - Buffer contents not reset (RAM-inferable); they are undefined until written.
- Buffer writes:
  - Accepted when `wr_en`=1 and state is not PLAY; written in one cycle.
  - `wr_en` during PLAY is ignored; the buffer is unchanged.
- States: IDLE, PLAY, DONE.
- Start acceptance:
  - `start` is accepted only in IDLE or DONE, only when `stop`=0 and `len`!=0.
  - `len`=0: start ignored, state unchanged.
  - `len`>DEPTH: clamped to DEPTH.
- On start accepted at cycle T:
  - Latch `len`, `loop`, `rate_div`; clear `done`; go to PLAY.
  - At T+1: x=buf[0], x_valid=1, busy=1.
- Sample timing:
  - Sample k appears at T+1+k*(rate_div+1), with x_valid=1 for exactly that cycle.
  - Between strobes, `x` holds the current sample and x_valid=0.
- End of sequence, non-loop:
  - After sample len-1 has been held for its full period, enter DONE at T+1+len*(rate_div+1).
  - In DONE: x=0, x_valid=0, busy=0, done=1.
- End of sequence, loop:
  - Index wraps from len-1 to 0 with no gap; the period stays uniform across the wrap.
  - Playback continues until `stop` or `reset`.
- Stop:
  - `stop`=1 in PLAY at cycle S: at S+1 state is IDLE, x=0, x_valid=0, busy=0, done=0.
  - `stop` in IDLE or DONE: no effect, except it blocks a same-cycle start.
- Start while in PLAY: ignored. Start and stop asserted together: stop wins.
- Reset mid-playback: next cycle all outputs take their reset values; the buffer is retained.
- Latched-value independence: `len`, `loop` and `rate_div` may change during PLAY without effect.
- Arithmetic:
  - Index counter is ADDR_W+1 bits and compares against the latched length.
  - Divider counts down from the latched `rate_div` to 0.
  - No sign interpretation of sample data; samples pass through bit-exact.

Test Plan:
- Write 1,2,3,4 to addr 0-3; start with len=4, rate_div=0, loop=0 at T -> x=1,2,3,4 at T+1..T+4 with x_valid=1 each cycle; at T+5 x=0, done=1, busy=0.
- Same buffer; start with len=4, rate_div=2 -> strobes at T+1,T+4,T+7,T+10 with x=1,2,3,4; x holds its value between strobes; done at T+13.
- Loop playback:
  - Start with len=3, rate_div=0, loop=1 -> x=1,2,3,1,2,3,1 continuously.
  - Stop at cycle S -> IDLE at S+1 with x=0, busy=0, done=0.
- Guards during and around playback:
  - `wr_en` to addr 0 with data 99 during PLAY -> ignored; a replay still outputs 1 first.
  - Start during PLAY -> ignored; timing unchanged.
  - Start with len=0 -> no response.
  - Start and stop together in IDLE -> stays IDLE.
- Clamping: fill all 16 entries with 10..25; start with len=20 -> exactly 16 samples, 10..25, then DONE.
- Reset mid-playback at cycle R -> at R+1 x=0, x_valid=0, busy=0, done=0; a new start (len=4) replays 1,2,3,4 from the retained buffer.

Source files
------------

// File: rtl/fir_sample_source_if.sv
// Purpose: host/sample bus between a controller and fir_sample_source.
// Latency: none, wires only.
// Backpressure: none; x_valid is a one-cycle strobe with no ready.
// Ports: master = host side (buffer writes, playback control, observes x);
//        slave = fir_sample_source side.
interface fir_sample_source_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W:0]   len;
  logic [DIV_W-1:0]  rate_div;
  logic [DATA_W-1:0] x;
  logic              x_valid;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop, len, rate_div,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop, len, rate_div,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/fir_sample_source.sv
// Purpose: sample buffer played out on x, one sample per (rate_div+1) cycles.
// Latency: first sample on x one cycle after an accepted start.
// Backpressure: none; the consumer must take each x_valid strobe.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries buffer
//        writes, start/stop/loop/len/rate_div control and x/x_valid/busy/done.
module fir_sample_source #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  fir_sample_source_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  rate_q, rate_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              x_valid_q, x_valid_d;

  // Sample store: no reset so it maps onto RAM; survives a mid-play reset.
  logic [DATA_W-1:0] buf_q [DEPTH];

  logic              start_ok;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   idx_nxt;

  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q != S_PLAY)) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    div_d     = div_q;
    rate_d    = rate_q;
    loop_d    = loop_q;
    x_d       = x_q;
    x_valid_d = 1'b0;
    idx_nxt   = idx_q + (ADDR_W+1)'(1);

    len_clamped = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    // stop blocks a same-cycle start; len==0 is not a playable sequence.
    start_ok = bus.start && !bus.stop && (bus.len != '0) && (state_q != S_PLAY);

    case (state_q)
      S_PLAY: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          x_d     = '0;
          idx_d   = '0;
          div_d   = '0;
        end else if (div_q != '0) begin
          // Hold the current sample for the rest of its period.
          div_d = div_q - DIV_W'(1);
        end else if (idx_nxt == len_q) begin
          idx_d = '0;
          if (loop_q) begin
            // Wrap straight to entry 0 so the period is uniform across the wrap.
            div_d     = rate_q;
            x_d       = buf_q[0];
            x_valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
            x_d     = '0;
          end
        end else begin
          idx_d     = idx_nxt;
          div_d     = rate_q;
          x_d       = buf_q[idx_nxt[ADDR_W-1:0]];
          x_valid_d = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new start; DONE clears on leaving.
        if (start_ok) begin
          state_d   = S_PLAY;
          len_d     = len_clamped;
          loop_d    = bus.loop;
          rate_d    = bus.rate_div;
          div_d     = bus.rate_div;
          idx_d     = '0;
          x_d       = buf_q[0];
          x_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      div_q     <= '0;
      rate_q    <= '0;
      loop_q    <= 1'b0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      div_q     <= div_d;
      rate_q    <= rate_d;
      loop_q    <= loop_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = (state_q == S_PLAY);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_fir_sample_source.sv
module tb_fir_sample_source;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DIV_W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_sample_source_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

  fir_sample_source #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // cyc = number of rising edges seen; "cycle c" is the interval after edge c.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard in cycle and value.
  always @(negedge clk) begin
    exp_t e;
    if (bus.x_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: cycle=%0d x=%0d, required no strobe", cyc, bus.x);
      end else begin
        e = sb.pop_front();
        if ((e.cyc != 32'(cyc)) || (e.val !== bus.x)) begin
          fails++;
          $display("FAIL strobe: got cycle=%0d x=%0d, required cycle=%0d x=%0d",
                   cyc, bus.x, e.cyc, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] x, input logic xv,
                         input logic busy, input logic done);
    check({tag, ".x"}, 32'(bus.x), 32'(x));
    check({tag, ".x_valid"}, 32'(bus.x_valid), 32'(xv));
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check({tag, ".done"}, 32'(bus.done), 32'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = DATA_W'(d);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Start is held during cycle T (returned); it is sampled at the end of T.
  task automatic start_play(input int len, input int rd, input logic lp, output int t);
    bus.len      = (ADDR_W+1)'(len);
    bus.rate_div = DIV_W'(rd);
    bus.loop     = lp;
    bus.start    = 1'b1;
    t = cyc;
    tick();
    bus.start    = 1'b0;
  endtask

  // Expected strobes: sample k at T+1+k*(rd+1), value base + (k mod modn).
  task automatic push_seq(input int t, input int rd, input int n, input int base, input int modn);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = 32'(t + 1 + k * (rd + 1));
      e.val = 16'(base + (k % modn));
      sb.push_back(e);
    end
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    bus.len      = '0;
    bus.rate_div = '0;
    repeat (3) tick();
    chk_out("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) wr(i, i + 1);

    // Full-rate single shot.
    start_play(4, 0, 1'b0, t);
    push_seq(t, 0, 4, 1, 4);
    check("fullrate.busy_T1", 32'(bus.busy), 32'd1);
    wait_to(t + 4);
    check("fullrate.done_T4", 32'(bus.done), 32'd0);
    wait_to(t + 5);
    chk_out("fullrate.end", 16'd0, 1'b0, 1'b0, 1'b1);

    // Divided rate; a write and a start during PLAY must both be ignored,
    // and changed len/loop/rate_div inputs must not affect this run.
    start_play(4, 2, 1'b0, t);
    push_seq(t, 2, 4, 1, 4);
    wait_to(t + 2);
    check("div.hold_x", 32'(bus.x), 32'd1);
    check("div.hold_valid", 32'(bus.x_valid), 32'd0);
    wr(0, 99);
    bus.len      = 5'd2;
    bus.rate_div = 8'd0;
    bus.loop     = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    wait_to(t + 12);
    check("div.done_T12", 32'(bus.done), 32'd0);
    wait_to(t + 13);
    chk_out("div.end", 16'd0, 1'b0, 1'b0, 1'b1);

    // Loop playback then stop; first sample 1 shows the in-PLAY write was dropped.
    start_play(3, 0, 1'b1, t);
    push_seq(t, 0, 7, 1, 3);
    wait_to(t + 7);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("loop.stop", 16'd0, 1'b0, 1'b0, 1'b0);

    // len == 0 is ignored.
    start_play(0, 0, 1'b0, t);
    repeat (3) tick();
    check("len0.busy", 32'(bus.busy), 32'd0);
    check("len0.done", 32'(bus.done), 32'd0);

    // start and stop together in IDLE: stop wins.
    bus.stop = 1'b1;
    start_play(4, 0, 1'b0, t);
    bus.stop = 1'b0;
    repeat (2) tick();
    check("startstop.busy", 32'(bus.busy), 32'd0);

    // Reset mid-playback, then replay from the retained buffer.
    start_play(4, 1, 1'b0, t);
    push_seq(t, 1, 2, 1, 4);
    wait_to(t + 3);
    reset = 1'b1;
    tick();
    chk_out("midreset", 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    start_play(4, 0, 1'b0, t);
    push_seq(t, 0, 4, 1, 4);
    wait_to(t + 5);
    check("replay.done", 32'(bus.done), 32'd1);

    // len above DEPTH clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++) wr(i, 10 + i);
    start_play(20, 0, 1'b0, t);
    push_seq(t, 0, DEPTH, 10, DEPTH);
    wait_to(t + DEPTH);
    check("clamp.busy_last", 32'(bus.busy), 32'd1);
    wait_to(t + DEPTH + 1);
    chk_out("clamp.end", 16'd0, 1'b0, 1'b0, 1'b1);

    repeat (4) tick();
    check("scoreboard.left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
